// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared constants and types for the QPSK transmit datapath.
//   SAMPLE_W     : width of the signed passband sample
//   CARRIER_AMP  : peak carrier amplitude
//   COS_TAB/SIN_TAB : one carrier cycle in 8 phase steps, 9-bit signed
//   state_t      : modulator FSM state
package qpsk_pkg;

    localparam int SAMPLE_W     = 10;
    localparam int LUT_W        = 9;
    localparam int CARRIER_AMP  = 255;
    // 255 * cos(45 deg) rounded to the nearest integer.
    localparam int CARRIER_DIAG = 180;

    typedef logic signed [LUT_W-1:0] lut_t;

    localparam lut_t LA = lut_t'(CARRIER_AMP);
    localparam lut_t LD = lut_t'(CARRIER_DIAG);
    localparam lut_t LZ = lut_t'(0);

    localparam lut_t COS_TAB [8] = '{LA, LD, LZ, -LD, -LA, -LD, LZ, LD};
    localparam lut_t SIN_TAB [8] = '{LZ, LD, LA, LD, LZ, -LD, -LA, -LD};

    typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/qpsk_carrier_lut.sv
// qpsk_carrier_lut: combinational carrier table lookup.
//   phase   in  3-bit carrier phase index (0..7, 45 degree steps)
//   cos_val out signed cosine sample at that phase
//   sin_val out signed sine sample at that phase
module qpsk_carrier_lut
    import qpsk_pkg::*;
(
    input  logic [2:0] phase,
    output lut_t       cos_val,
    output lut_t       sin_val
);

    assign cos_val = COS_TAB[phase];
    assign sin_val = SIN_TAB[phase];

endmodule

// File: rtl/qpsk_modulate.sv
// qpsk_modulate: serial bits -> (I,Q) symbols -> passband samples I*cos + Q*sin.
//   clk, rst_n  clock, asynchronous active-low reset
//   bit_in      serial data bit (1 -> +1, 0 -> -1); first of a pair is I
//   bit_valid   bit_in valid; transfer when bit_valid && bit_ready
//   bit_ready   high while no complete pair is waiting
//   qpsk_out    registered signed passband sample, 0 when idle
//   busy        high while a symbol is being transmitted
//   sym_start   pulse with the first sample of each symbol
// SAMPLES_PER_SYMBOL must be a non-zero multiple of 8 so every symbol holds
// whole carrier cycles and the phase index can be the low counter bits.
module qpsk_modulate
    import qpsk_pkg::*;
#(
    parameter int SAMPLES_PER_SYMBOL = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic signed [SAMPLE_W-1:0] qpsk_out,
    output logic                       busy,
    output logic                       sym_start
);

    localparam int               CNT_W = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    // ---------------- bit collector ----------------
    logic bit_cnt;
    logic pair_i, pair_q, pair_full;
    logic xfer, load;

    assign bit_ready = !pair_full;
    assign xfer      = bit_valid && bit_ready;

    // load needs pair_full and xfer needs !pair_full, so the clear and the
    // set of pair_full below can never happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 1'b0;
            pair_i    <= 1'b0;
            pair_q    <= 1'b0;
            pair_full <= 1'b0;
        end else begin
            if (load) pair_full <= 1'b0;
            if (xfer) begin
                if (!bit_cnt) begin
                    pair_i  <= bit_in;
                    bit_cnt <= 1'b1;
                end else begin
                    pair_q    <= bit_in;
                    bit_cnt   <= 1'b0;
                    pair_full <= 1'b1;
                end
            end
        end
    end

    // ---------------- FSM / sample counter ----------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] sample_cnt, cnt_nxt;
    logic             sym_i, sym_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            sym_i      <= 1'b0;
            sym_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
            if (load) begin
                sym_i <= pair_i;
                sym_q <= pair_q;
            end
        end
    end

    // Counter wraps to 0 on every load, so carrier phase restarts per symbol.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pair_full) begin
                    load      = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_cnt == LAST) begin
                    if (pair_full) load = 1'b1;   // back-to-back, no gap
                    else           state_nxt = IDLE;
                end else begin
                    cnt_nxt = sample_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

    // ---------------- mixer / adder ----------------
    lut_t cos_val, sin_val;

    qpsk_carrier_lut u_lut (
        .phase   (sample_cnt[2:0]),
        .cos_val (cos_val),
        .sin_val (sin_val)
    );

    logic signed [SAMPLE_W-1:0] cos_ext, sin_ext, term_i, term_q, sample;

    // |cos| + |sin| peaks at 360, inside the 10-bit signed range.
    assign cos_ext = SAMPLE_W'(cos_val);
    assign sin_ext = SAMPLE_W'(sin_val);
    assign term_i  = sym_i ? cos_ext : -cos_ext;
    assign term_q  = sym_q ? sin_ext : -sin_ext;
    assign sample  = term_i + term_q;

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qpsk_out  <= '0;
            sym_start <= 1'b0;
        end else if (state == ACTIVE) begin
            qpsk_out  <= sample;
            sym_start <= (sample_cnt == '0);
        end else begin
            qpsk_out  <= '0;
            sym_start <= 1'b0;
        end
    end

endmodule
